seven_seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for an N-digit common-segment 7-segment display.
//   One BCD-to-7-seg decoder is shared by all digits; this block sequences it by selecting
//   one digit per time slot, driving that digit's BCD code to the decoder and its enable.
//   New display values are double-buffered, so a frame never shows a mix of old and new digits.

---
 rtl/seven_seg_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for an N-digit multiplexed 7-segment display sharing one BCD decoder.
// Double-buffered display value, per-slot blanking guard and leading-zero blanking.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    lzb_en,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    load_ack,
  output logic                    frame_done
);

  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W:0]   BLANK_LIM = (CNT_W + 1)'(BLANK_CYCLES);

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_t;

  logic [IDX_W-1:0]      idx_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [VAL_W-1:0]      shadow_q;
  logic [VAL_W-1:0]      pending_q;
  logic                  pending_valid_q;

  logic                  slot_end;
  logic                  boundary;
  logic [IDX_W-1:0]      idx_nxt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [VAL_W-1:0]      shadow_nxt;
  logic [NUM_DIGITS-1:0] sup;
  logic                  zero_run;
  logic [3:0]            digit_nxt;
  phase_t                phase_nxt;

  // Next slot position, next shadow value and the phase of the upcoming cycle.
  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    boundary = slot_end && (idx_q == IDX_LAST);
    cnt_nxt  = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_nxt  = idx_q;
    if (slot_end) begin
      idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    shadow_nxt = shadow_q;
    if (boundary) begin
      if (load) begin
        shadow_nxt = value_in;
      end else if (pending_valid_q) begin
        shadow_nxt = pending_q;
      end
    end

    // A digit is a leading zero when it and every more significant digit are zero.
    zero_run = 1'b1;
    sup      = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      zero_run = zero_run && (shadow_nxt[4*i +: 4] == 4'd0);
      sup[i]   = zero_run;
    end

    digit_nxt = shadow_nxt[{idx_nxt, 2'b00} +: 4];
    phase_nxt = PH_SHOW;
    if (({1'b0, cnt_nxt} < BLANK_LIM) || (lzb_en && sup[idx_nxt])) begin
      phase_nxt = PH_BLANK;
    end
  end

  // Outputs are registered so they line up with the slot position held in idx_q/cnt_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q           <= '0;
      cnt_q           <= '0;
      shadow_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      bcd_out         <= 4'hF;
      digit_en        <= '0;
      load_ack        <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      idx_q      <= idx_nxt;
      cnt_q      <= cnt_nxt;
      shadow_q   <= shadow_nxt;
      load_ack   <= load;
      frame_done <= boundary;

      if (load && !boundary) begin
        pending_q       <= value_in;
        pending_valid_q <= 1'b1;
      end else if (boundary) begin
        pending_valid_q <= 1'b0;
      end

      case (phase_nxt)
        PH_SHOW: begin
          bcd_out  <= digit_nxt;
          digit_en <= NUM_DIGITS'(1) << idx_nxt;
        end
        default: begin
          bcd_out  <= 4'hF;
          digit_en <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: N=4, REFRESH_DIV=8, with BLANK_CYCLES=2 and 0 builds
// driven by the same stimulus. pos counts cycles since reset release (cnt=pos%8, idx=(pos/8)%4).
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        lzb_en = 1'b0;
  logic [15:0] value_in = 16'h0;

  logic [3:0] bcd_out, bcd_out0;
  logic [3:0] digit_en, digit_en0;
  logic       load_ack, load_ack0;
  logic       frame_done, frame_done0;

  int n_cmp = 0;
  int n_err = 0;
  int pos = 0;

  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in), .lzb_en(lzb_en),
    .bcd_out(bcd_out), .digit_en(digit_en), .load_ack(load_ack), .frame_done(frame_done)
  );

  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in), .lzb_en(lzb_en),
    .bcd_out(bcd_out0), .digit_en(digit_en0), .load_ack(load_ack0), .frame_done(frame_done0)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    pos++;
  endtask

  task automatic goto(input int target);
    while (pos < target) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @pos %0d: observed %0h expected %0h", tag, pos, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] exp_bcd, input logic [3:0] exp_en);
    chk({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
    chk({tag, "_en"}, 32'(digit_en), 32'(exp_en));
  endtask

  task automatic chk_out0(input string tag, input logic [3:0] exp_bcd, input logic [3:0] exp_en);
    chk({tag, "_bcd0"}, 32'(bcd_out0), 32'(exp_bcd));
    chk({tag, "_en0"}, 32'(digit_en0), 32'(exp_en));
  endtask

  // Guard cycle (cnt 1) must be dark; cnt 5 shows digit s of v unless marked dark.
  task automatic chk_slot(input int base, input int s, input logic [15:0] v, input logic [3:0] dark);
    logic [3:0] d;
    d = v[4*s +: 4];
    goto(base + s*8 + 1);
    chk_out($sformatf("f%0d_s%0d_guard", base/32, s), 4'hF, 4'h0);
    goto(base + s*8 + 5);
    if (dark[s]) chk_out($sformatf("f%0d_s%0d_dark", base/32, s), 4'hF, 4'h0);
    else         chk_out($sformatf("f%0d_s%0d_show", base/32, s), d, 4'(1 << s));
  endtask

  task automatic do_load(input logic [15:0] v);
    load     = 1'b1;
    value_in = v;
    tick();
    load     = 1'b0;
  endtask

  initial begin
    // Reset held 3 cycles with load asserted
    rst = 1'b1; load = 1'b1; value_in = 16'h7777;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk_out($sformatf("rst%0d", k), 4'hF, 4'h0);
      chk($sformatf("rst%0d_ack", k), 32'(load_ack), 32'd0);
      chk($sformatf("rst%0d_fd", k), 32'(frame_done), 32'd0);
    end
    rst = 1'b0; load = 1'b0; value_in = 16'h0; pos = 0;

    // Frame 0: shadow is 0
    chk_out("rel_p0", 4'hF, 4'h0);
    chk("rel_p0_ack", 32'(load_ack), 32'd0);
    chk("rel_p0_fd", 32'(frame_done), 32'd0);
    goto(1);  chk_out0("nb_p1", 4'h0, 4'b0001);
    goto(2);  chk_out("f0_s0", 4'h0, 4'b0001);
    goto(4);  do_load(16'h1234);
    chk("ack_1234", 32'(load_ack), 32'd1);
    tick();   chk("ack_1234_off", 32'(load_ack), 32'd0);
    goto(11); chk_out("f0_s1_old", 4'h0, 4'b0010);
    goto(31); chk("fd_p31", 32'(frame_done), 32'd0);
    chk_out("f0_s3_old", 4'h0, 4'b1000);
    goto(32); chk("fd_p32", 32'(frame_done), 32'd1);
    chk_out("f1_p32", 4'hF, 4'h0);
    chk_out0("nb_p32", 4'h4, 4'b0001);
    goto(33); chk("fd_p33", 32'(frame_done), 32'd0);

    // Frame 1: 1234, a load at slot 2 must not tear the frame
    chk_slot(32, 0, 16'h1234, 4'b0000);
    chk_slot(32, 1, 16'h1234, 4'b0000);
    goto(48); do_load(16'h5678);
    chk("ack_5678", 32'(load_ack), 32'd1);
    chk_slot(32, 2, 16'h1234, 4'b0000);
    chk_slot(32, 3, 16'h1234, 4'b0000);
    goto(63); chk("fd_p63", 32'(frame_done), 32'd0);
    goto(64); chk("fd_p64", 32'(frame_done), 32'd1);

    // Frame 2: 5678 with lzb on (no leading zeros), load 0045 mid-frame
    lzb_en = 1'b1;
    chk_slot(64, 0, 16'h5678, 4'b0000);
    goto(72); do_load(16'h0045);
    chk_slot(64, 1, 16'h5678, 4'b0000);
    chk_slot(64, 2, 16'h5678, 4'b0000);
    chk_slot(64, 3, 16'h5678, 4'b0000);

    // Frame 3: 0045 -> digits 3,2 dark
    chk_slot(96, 0, 16'h0045, 4'b1100);
    chk_slot(96, 1, 16'h0045, 4'b1100);
    chk_slot(96, 2, 16'h0045, 4'b1100);
    goto(120); do_load(16'h0000);
    chk_slot(96, 3, 16'h0045, 4'b1100);

    // Frame 4: 0000 -> only digit 0 shows 0
    chk_slot(128, 0, 16'h0000, 4'b1110);
    chk_slot(128, 1, 16'h0000, 4'b1110);
    chk_slot(128, 2, 16'h0000, 4'b1110);
    goto(152); do_load(16'h0A05);
    chk_slot(128, 3, 16'h0000, 4'b1110);

    // Frame 5: 0A05 -> digit 2 shows A, digit 1 shows 0, digit 3 dark
    chk_slot(160, 0, 16'h0A05, 4'b1000);
    chk_slot(160, 1, 16'h0A05, 4'b1000);
    chk_slot(160, 2, 16'h0A05, 4'b1000);
    chk_slot(160, 3, 16'h0A05, 4'b1000);
    goto(190); lzb_en = 1'b0;
    goto(191); do_load(16'h9999);
    chk("ack_9999", 32'(load_ack), 32'd1);
    chk("fd_p192", 32'(frame_done), 32'd1);

    // Frame 6: bypass load shows 9999 immediately; two loads, latest wins
    chk_slot(192, 0, 16'h9999, 4'b0000);
    goto(200); do_load(16'h1111);
    chk_slot(192, 1, 16'h9999, 4'b0000);
    goto(208); do_load(16'h2222);
    chk_slot(192, 2, 16'h9999, 4'b0000);
    chk_slot(192, 3, 16'h9999, 4'b0000);

    // Frame 7: 2222, then reset at idx 2 cnt 5 with 3333 pending
    chk_slot(224, 0, 16'h2222, 4'b0000);
    chk_slot(224, 1, 16'h2222, 4'b0000);
    goto(240); do_load(16'h3333);
    goto(245); chk_out("f7_s2_pre_rst", 4'h2, 4'b0100);
    rst = 1'b1;
    tick();
    chk_out("midrst", 4'hF, 4'h0);
    chk_out0("midrst", 4'hF, 4'h0);
    chk("midrst_ack", 32'(load_ack), 32'd0);
    chk("midrst_fd", 32'(frame_done), 32'd0);
    rst = 1'b0; pos = 0;

    // After reset: shadow 0 and the pending 3333 dropped
    goto(2);  chk_out("post_s0", 4'h0, 4'b0001);
    goto(11); chk_out("post_s1", 4'h0, 4'b0010);
    goto(32); chk("post_fd", 32'(frame_done), 32'd1);
    chk_out0("post_nb_p32", 4'h0, 4'b0001);
    goto(45); chk_out("post_f1_s1", 4'h0, 4'b0010);
    goto(48); chk_out0("nb_s2_c0", 4'h0, 4'b0100);
    goto(49); chk_out0("nb_s2_c1", 4'h0, 4'b0100);
    goto(55); chk_out0("nb_s2_c7", 4'h0, 4'b0100);
    goto(56); chk_out0("nb_s3_c0", 4'h0, 4'b1000);
    chk("nb_fd_p56", 32'(frame_done0), 32'd0);
    goto(64); chk("nb_fd_p64", 32'(frame_done0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
